// File: rtl/reescalador_ctrl_if.sv
// Handshake/bus bundle between the reescalador sequencer and its neighbours.
//   start/qp/busy           : block launch from the coefficient source side
//   in_valid/in_ready/coef_in : source coefficient stream
//   dp_*                    : registered coefficient stream into the rescaler
//   done                    : one-cycle block-complete pulse
// slave = the controller, master = whoever drives it (source + datapath).
interface reescalador_ctrl_if #(
  parameter int COEF_W = 16,
  parameter int QP_W   = 6
);
  logic                     start;
  logic [QP_W-1:0]          qp;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] coef_in;
  logic                     dp_valid;
  logic                     dp_ready;
  logic signed [COEF_W-1:0] dp_coef;
  logic [3:0]               dp_pos;
  logic [3:0]               dp_qp_div6;
  logic [2:0]               dp_qp_mod6;
  logic                     done;

  modport slave (
    input  start, qp, in_valid, coef_in, dp_ready,
    output busy, in_ready, dp_valid, dp_coef, dp_pos, dp_qp_div6, dp_qp_mod6, done
  );

  modport master (
    output start, qp, in_valid, coef_in, dp_ready,
    input  busy, in_ready, dp_valid, dp_coef, dp_pos, dp_qp_div6, dp_qp_mod6, done
  );
endinterface

// File: rtl/reescalador_ctrl.sv
// Sequencer in front of the reescalador (inverse-quantisation) datapath.
// Per 4x4 block: latch QP (clamped to 51), derive qp/6 and qp%6 by repeated
// subtraction (one step per cycle), then pass N_COEF coefficients through a
// single output register stage tagged with their scan position, and pulse
// done once the last one is taken by the datapath.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : reescalador_ctrl_if.slave (start/qp/busy, source stream,
//           datapath stream, qp/6, qp%6, done)
module reescalador_ctrl #(
  parameter int COEF_W = 16,
  parameter int N_COEF = 16,
  parameter int QP_W   = 6
) (
  input  logic clk,
  input  logic reset,
  reescalador_ctrl_if.slave bus
);

  // One extra bit so cnt can sit at N_COEF without wrapping to 0.
  localparam int CW = $clog2(N_COEF) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIV    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [QP_W-1:0]          rem_q, rem_d;
  logic [3:0]               quo_q, quo_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     dp_valid_q, dp_valid_d;
  logic signed [COEF_W-1:0] dp_coef_q, dp_coef_d;
  logic [3:0]               dp_pos_q, dp_pos_d;
  logic [3:0]               div6_q, div6_d;
  logic [2:0]               mod6_q, mod6_d;
  logic                     done_q, done_d;

  logic in_ready, in_acc, dp_acc;

  always_comb begin
    // The output register may be refilled in the same cycle it drains.
    in_ready = (state_q == S_STREAM) && (cnt_q < CW'(N_COEF)) &&
               (!dp_valid_q || bus.dp_ready);
    in_acc   = bus.in_valid && in_ready;
    dp_acc   = dp_valid_q && bus.dp_ready;

    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_coef_d  = dp_coef_q;
    dp_pos_d   = dp_pos_q;
    div6_d     = div6_q;
    mod6_d     = mod6_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = (bus.qp > QP_W'(51)) ? QP_W'(51) : bus.qp;
          quo_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_q >= QP_W'(6)) begin
          rem_d = rem_q - QP_W'(6);
          quo_d = quo_q + 4'd1;
        end else begin
          div6_d  = quo_q;
          mod6_d  = rem_q[2:0];
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_acc) begin
          dp_coef_d  = bus.coef_in;
          dp_pos_d   = 4'(cnt_q);
          dp_valid_d = 1'b1;
          cnt_d      = cnt_q + CW'(1);
        end else if (dp_acc) begin
          dp_valid_d = 1'b0;
        end
        // Last position taken: no input accept can coincide since cnt is full.
        if (dp_acc && dp_pos_q == 4'(N_COEF - 1)) begin
          done_d     = 1'b1;
          dp_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_coef_q  <= '0;
      dp_pos_q   <= '0;
      div6_q     <= '0;
      mod6_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_coef_q  <= dp_coef_d;
      dp_pos_q   <= dp_pos_d;
      div6_q     <= div6_d;
      mod6_q     <= mod6_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.in_ready   = in_ready;
  assign bus.dp_valid   = dp_valid_q;
  assign bus.dp_coef    = dp_coef_q;
  assign bus.dp_pos     = dp_pos_q;
  assign bus.dp_qp_div6 = div6_q;
  assign bus.dp_qp_mod6 = mod6_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_reescalador_ctrl.sv
// Directed bench for reescalador_ctrl: a table of blocks (qp, stimulus mode,
// expected qp/6, qp%6 and DIV latency) run back-to-back, plus hand sequences
// for reset state and an asynchronous reset mid-block.
module tb_reescalador_ctrl;
  localparam int COEF_W = 16;
  localparam int N_COEF = 16;
  localparam int QP_W   = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reescalador_ctrl_if #(.COEF_W(COEF_W), .QP_W(QP_W)) bus();

  reescalador_ctrl #(.COEF_W(COEF_W), .N_COEF(N_COEF), .QP_W(QP_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int qp;
    bit tog;    // in_valid toggles 1,0,1,0...
    bit stall;  // dp_ready low for 3 cycles while pos 5 is presented
    bit smid;   // pulse start with qp=12 mid-stream (must be ignored)
    int ediv;
    int emod;
    int ecyc;   // expected DIV cycles
  } vec_t;

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},     bus.busy, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_dp_valid"}, bus.dp_valid, 0);
    chk({tag, "_dp_coef"},  bus.dp_coef, 0);
    chk({tag, "_dp_pos"},   bus.dp_pos, 0);
    chk({tag, "_div6"},     bus.dp_qp_div6, 0);
    chk({tag, "_mod6"},     bus.dp_qp_mod6, 0);
    chk({tag, "_done"},     bus.done, 0);
  endtask

  // Launch a block in the current cycle and stream coefficients 1..N_COEF.
  // Returns after the cycle in which done is seen.
  task automatic run_block(input vec_t v);
    int  sent = 0, recv = 0, divcyc = 0, stalls = 0, cyc = 0;
    bit  ph = 1'b1, fin = 1'b0, mid_done = 1'b0;
    bus.qp       = QP_W'(v.qp);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.coef_in  = COEF_W'(1);
    bus.dp_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.qp    = '0;
    chk("busy_after_start", bus.busy, 1);
    chk("done_low_after_start", bus.done, 0);
    while (!fin) begin
      bus.dp_ready = 1'b1;
      if (v.stall && stalls < 3 && (stalls > 0 || (bus.dp_valid && bus.dp_pos == 4'd5))) begin
        bus.dp_ready = 1'b0;
        stalls++;
      end
      bus.in_valid = v.tog ? ph : 1'b1;
      ph = ~ph;
      bus.coef_in = COEF_W'(sent + 1);
      if (v.smid && sent == 8 && !mid_done) begin
        bus.start = 1'b1;
        bus.qp    = QP_W'(12);
        mid_done  = 1'b1;
      end
      #1;
      if (sent == 0 && !bus.in_ready && !bus.dp_valid) divcyc++;
      if (!bus.dp_ready) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_dp_valid", bus.dp_valid, 1);
        chk("stall_pos", bus.dp_pos, 5);
        chk("stall_coef", bus.dp_coef, 6);
      end
      if (bus.dp_valid && bus.dp_ready) begin
        chk("dp_pos", bus.dp_pos, recv);
        chk("dp_coef", bus.dp_coef, recv + 1);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) fin = 1'b1;
      cyc++;
      if (!fin && cyc > 200) begin
        chk("block_timeout", 0, 1);
        fin = 1'b1;
      end
    end
    chk("recv_count", recv, N_COEF);
    chk("sent_count", sent, N_COEF);
    chk("div_cycles", divcyc, v.ecyc);
    chk("div6", bus.dp_qp_div6, v.ediv);
    chk("mod6", bus.dp_qp_mod6, v.emod);
    chk("busy_at_done", bus.busy, 0);
    chk("dp_valid_at_done", bus.dp_valid, 0);
    if (v.stall) chk("stall_cycles", stalls, 3);
    bus.in_valid = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{qp: 0,  tog: 0, stall: 0, smid: 0, ediv: 0, emod: 0, ecyc: 1};
    tbl[1] = '{qp: 51, tog: 0, stall: 0, smid: 0, ediv: 8, emod: 3, ecyc: 9};
    tbl[2] = '{qp: 29, tog: 0, stall: 0, smid: 0, ediv: 4, emod: 5, ecyc: 5};
    tbl[3] = '{qp: 63, tog: 0, stall: 0, smid: 0, ediv: 8, emod: 3, ecyc: 9};
    tbl[4] = '{qp: 6,  tog: 0, stall: 1, smid: 0, ediv: 1, emod: 0, ecyc: 2};
    tbl[5] = '{qp: 17, tog: 1, stall: 0, smid: 0, ediv: 2, emod: 5, ecyc: 3};
    tbl[6] = '{qp: 35, tog: 0, stall: 0, smid: 1, ediv: 5, emod: 5, ecyc: 6};
    tbl[7] = '{qp: 12, tog: 0, stall: 0, smid: 0, ediv: 2, emod: 0, ecyc: 3};

    bus.start = 1'b0; bus.qp = '0; bus.in_valid = 1'b1;
    bus.coef_in = '0; bus.dp_ready = 1'b1;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    // in_valid while IDLE must not be consumed.
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_busy", bus.busy, 0);

    // Blocks run back-to-back: each start lands in the done cycle of the last.
    for (int i = 0; i < 8; i++) run_block(tbl[i]);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);

    // Asynchronous reset while pos 7 is presented.
    begin
      int k = 0, cyc = 0;
      bus.qp = QP_W'(29); bus.start = 1'b1;
      bus.in_valid = 1'b1; bus.dp_ready = 1'b1;
      bus.coef_in = COEF_W'(1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!(bus.dp_valid && bus.dp_pos == 4'd7) && cyc < 50) begin
        if (bus.in_ready) k++;
        bus.coef_in = COEF_W'(k + 1);
        @(posedge clk); #1;
        cyc++;
      end
      chk("reach_pos7", bus.dp_pos, 7);
      chk("div6_before_reset", bus.dp_qp_div6, 4);
      #2 reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      repeat (3) begin
        @(posedge clk); #1;
        chk("no_done_in_reset", bus.done, 0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      chk("no_done_after_reset", bus.done, 0);
      chk("idle_after_reset", bus.busy, 0);
    end
    run_block(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reescalador_ctrl.md
Name: reescalador_ctrl

Overview:
- Sequencer in front of the reescalador (inverse-quantisation rescaler) datapath.
- Per 4x4 block: latches QP, computes qp/6 and qp%6 iteratively, then streams 16 coefficients into the datapath over valid/ready.
- Tags each coefficient with its scan position (0..15) for the datapath's LevelScale lookup, and pulses done when the block completes.
- Sits between the coefficient source and the rescaler datapath; the refmod checker compares datapath output per block.

Parameters:
- COEF_W, 16, coefficient width in bits
- N_COEF, 16, coefficients per block (power of 2, at most 16)
- QP_W, 6, QP width in bits

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a block; sampled only in IDLE
- qp  in  QP_W  quantiser parameter, sampled with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  source coefficient valid
- in_ready  out  1  controller accepts coefficient
- coef_in  in  COEF_W  signed source coefficient
- dp_valid  out  1  coefficient presented to datapath
- dp_ready  in  1  datapath accepts
- dp_coef  out  COEF_W  registered coefficient
- dp_pos  out  4  scan index of dp_coef
- dp_qp_div6  out  4  qp/6, stable from end of DIV to end of block
- dp_qp_mod6  out  3  qp%6, same stability as dp_qp_div6
- done  out  1  one-cycle pulse when the last coefficient is accepted by the datapath

Behaviour:
- Reset (async, any state): state=IDLE; busy, in_ready, dp_valid, done=0; dp_coef, dp_pos, dp_qp_div6, dp_qp_mod6=0; counters=0.
- FSM states: IDLE, DIV, STREAM.
- IDLE:
  - On start=1: latch rem=min(qp,51); quo=0; cnt=0; go to DIV.
  - Start with qp>51 clamps to 51.
- DIV, one step per cycle:
  - If rem>=6: rem-=6, quo+=1.
  - Else: dp_qp_div6=quo, dp_qp_mod6=rem[2:0], go to STREAM.
  - Latency = floor(qp/6)+1 cycles: qp=0 takes 1 cycle; qp=51 takes 9 cycles.
- STREAM:
  - Single output register stage; in_ready = (state==STREAM) && (cnt<N_COEF) && (!dp_valid || dp_ready). Combinational.
  - Input accept (in_valid && in_ready): dp_coef<=coef_in, dp_pos<=cnt, dp_valid<=1, cnt<=cnt+1.
  - Datapath accept without simultaneous input accept: dp_valid<=0.
  - Simultaneous datapath accept and input accept: dp_valid stays 1 and the new coefficient replaces the old one. Full throughput is 1 coefficient/cycle.
  - dp_valid=1 and dp_ready=0: dp_coef and dp_pos hold; in_ready=0.
  - cnt width is log2(N_COEF)+1 bits, so cnt reaches N_COEF without wrapping. After cnt==N_COEF, in_ready stays 0.
  - Datapath accept with dp_pos==N_COEF-1: done=1 for that cycle (registered, visible next cycle); state goes to IDLE; dp_valid goes to 0.
  - Coefficient latency is 1 cycle: source accept to dp_valid.
- start is ignored while busy=1.
- A new start in the cycle after return to IDLE is accepted, giving back-to-back blocks.
- dp_qp_div6 and dp_qp_mod6 keep their last values in IDLE.
- in_valid outside STREAM is ignored and no data is consumed.
- Reset asserted mid-block aborts the block: no done pulse, and partial data is discarded.
- Bit widths: dp_qp_div6 max 8 (fits 4 bits); dp_qp_mod6 max 5.

Test Plan:
- qp=0, start; 16 coefs 1..16 with in_valid and dp_ready held high -> DIV takes 1 cycle; div6=0, mod6=0; dp_pos 0..15 on consecutive cycles with dp_coef=pos+1; done pulses once after 16th accept.
- qp=51 -> 9 DIV cycles; div6=8, mod6=3. qp=29 -> div6=4, mod6=5 after 5 cycles. qp=63 -> clamped, div6=8, mod6=3.
- Backpressure: dp_ready=0 for 3 cycles at pos 5 -> dp_coef and dp_pos=5 stable; in_ready=0; no coefficient lost or duplicated; done still follows pos 15.
- in_valid toggling 1,0,1,0 -> dp_pos strictly increments per accepted coefficient; total 16; done after the last accept.
- start pulsed during STREAM with qp=12 -> ignored; div6/mod6 unchanged; back-to-back start right after done -> second block starts with new qp.
- Reset asserted asynchronously at pos 7 -> all outputs 0 immediately, no done; next start runs a full clean block.
